// File: rtl/hazard_pkg.sv
// Shared constants for the scoreboard hazard unit: forward-select encodings,
// producer latency codes and the default divider occupancy.
package hazard_pkg;

    localparam int FWD_RF = 0;
    localparam int FWD_E  = 1;
    localparam int FWD_M  = 2;
    localparam int FWD_W  = 3;

    localparam int LAT_ALU = 0;
    localparam int LAT_MEM = 1;
    localparam int LAT_WB  = 2;

    localparam int DIV_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/hazard_sb_entry.sv
// Pending-write record for one architectural register: the age of the newest
// in-flight producer and the age at which its result becomes forwardable.
module hazard_sb_entry #(
    parameter int NSTAGE = 3,
    parameter int SW     = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          issue,
    input  logic [SW-1:0] issue_lat,
    input  logic          adv,
    input  logic          flush,
    output logic          valid,
    output logic [SW-1:0] age,
    output logic [SW-1:0] rdy
);

    // A new producer wins over both the flush kill and the age-out of the old one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            age   <= '0;
            rdy   <= '0;
        end else if (issue) begin
            valid <= 1'b1;
            age   <= '0;
            rdy   <= issue_lat;
        end else if (valid && flush && (age <= SW'(1))) begin
            valid <= 1'b0;
        end else if (valid && adv) begin
            if (age == SW'(NSTAGE - 1)) begin
                valid <= 1'b0;
            end else begin
                age <= age + SW'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register pending-write table, RAW stall and
// forward-source selection for D, divider busy counter with HI/LO interlock.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int AW         = $clog2(NREG),
    parameter int NSTAGE     = 3,
    parameter int SW         = $clog2(NSTAGE + 1),
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rs,
    input  logic [AW-1:0] issue_rt,
    input  logic          issue_rs_used,
    input  logic          issue_rt_used,
    input  logic          issue_wr_en,
    input  logic [AW-1:0] issue_wr_reg,
    input  logic [SW-1:0] issue_lat,
    input  logic          issue_is_div,
    input  logic          issue_hilo_use,
    input  logic          pipe_adv,
    input  logic          flush,
    output logic [SW-1:0] fwd_a_sel,
    output logic [SW-1:0] fwd_b_sel,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic          div_busy,
    output logic          div_abort
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [NREG-1:0] ent_valid;
    logic [SW-1:0]   ent_age [NREG];
    logic [SW-1:0]   ent_rdy [NREG];

    logic          accept;
    logic          haz_a;
    logic          haz_b;
    logic          raw_stall;
    logic          hilo_stall;
    logic [CW-1:0] div_cnt;
    logic [SW-1:0] div_age;

    // $0 has no producer; a constant empty slot keeps the source mux uniform.
    assign ent_valid[0] = 1'b0;
    assign ent_age[0]   = '0;
    assign ent_rdy[0]   = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        hazard_sb_entry #(
            .NSTAGE (NSTAGE),
            .SW     (SW)
        ) u_entry (
            .clk       (clk),
            .resetn    (resetn),
            .issue     (accept && issue_wr_en && (issue_wr_reg == AW'(r))),
            .issue_lat (issue_lat),
            .adv       (pipe_adv),
            .flush     (flush),
            .valid     (ent_valid[r]),
            .age       (ent_age[r]),
            .rdy       (ent_rdy[r])
        );
    end

    always_comb begin
        haz_a = issue_rs_used && (issue_rs != '0) && ent_valid[issue_rs]
                && (ent_age[issue_rs] < ent_rdy[issue_rs]);
        haz_b = issue_rt_used && (issue_rt != '0) && ent_valid[issue_rt]
                && (ent_age[issue_rt] < ent_rdy[issue_rt]);

        fwd_a_sel = SW'(FWD_RF);
        if (issue_rs_used && ent_valid[issue_rs] && !haz_a) begin
            fwd_a_sel = SW'(FWD_E) + ent_age[issue_rs];
        end

        fwd_b_sel = SW'(FWD_RF);
        if (issue_rt_used && ent_valid[issue_rt] && !haz_b) begin
            fwd_b_sel = SW'(FWD_E) + ent_age[issue_rt];
        end
    end

    assign div_busy   = (div_cnt != '0);
    assign raw_stall  = issue_valid && (haz_a || haz_b);
    assign hilo_stall = issue_valid && issue_hilo_use && div_busy;
    assign stallD     = raw_stall || hilo_stall;
    assign stallF     = stallD && !flush;
    assign flushE     = flush || stallD;
    assign accept     = issue_valid && !stallD && !flush;

    // A divide still in E or M when the flush hits is being killed with it.
    assign div_abort  = flush && div_busy && (div_age < SW'(NSTAGE - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            div_age <= '0;
        end else begin
            if (div_abort) begin
                div_cnt <= '0;
            end else if (accept && issue_is_div) begin
                div_cnt <= CW'(DIV_CYCLES);
            end else if (div_busy) begin
                div_cnt <= div_cnt - CW'(1);
            end

            if (accept && issue_is_div) begin
                div_age <= '0;
            end else if (pipe_adv && (div_age != SW'(NSTAGE))) begin
                div_age <= div_age + SW'(1);
            end
        end
    end

endmodule
